// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking keypad.
// State encoding and timing defaults live here so the top and the bench agree.
package parking_pkg;

    localparam int DEF_PASS_W       = 4;
    localparam int DEF_MAX_TRIES    = 3;
    localparam int DEF_RESP_TIMEOUT = 4;
    localparam int DEF_GRANT_CYCLES = 8;
    localparam int DEF_LOCK_CYCLES  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_REQUEST = 3'd2,
        ST_WAIT    = 3'd3,
        ST_GRANT   = 3'd4,
        ST_LOCKOUT = 3'd5
    } parking_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/parking_timer.sv
// Loadable down-counter with a zero flag, shared by the WAIT, GRANT and LOCKOUT phases.
// Load wins over decrement; the count holds at zero instead of wrapping.
module parking_timer
    import parking_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/parking_keypad.sv
// Parking keypad controller: collects a serial password, requests the gate, handles grant/timeout.
// Define PARKING_LOCKOUT_EN to build the MAX_TRIES lockout; otherwise failures saturate at 3.
module parking_keypad
    import parking_pkg::*;
#(
    parameter int PASS_W       = DEF_PASS_W,
    parameter int MAX_TRIES    = DEF_MAX_TRIES,
    parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT,
    parameter int GRANT_CYCLES = DEF_GRANT_CYCLES,
    parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              car_present,
    input  logic              key_valid,
    input  logic              key_bit,
    input  logic              cancel,
    input  logic              gate_ok,
    output logic              sensor,
    output logic [PASS_W-1:0] pass,
    output logic              entry_led,
    output logic              lockout,
    output logic [1:0]        fail_cnt
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_COLLECT = ST_COLLECT;
    localparam logic [2:0] S_REQUEST = ST_REQUEST;
    localparam logic [2:0] S_WAIT    = ST_WAIT;
    localparam logic [2:0] S_GRANT   = ST_GRANT;
    localparam logic [2:0] S_LOCKOUT = ST_LOCKOUT;

    localparam int CNT_W = $clog2(PASS_W + 1);
    localparam int TMR_W = $clog2(max3(RESP_TIMEOUT, GRANT_CYCLES, LOCK_CYCLES) + 1);

    // fail_cnt is only two bits wide, so larger try limits could never be reached.
    if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_max_tries_range
        $error("parking_keypad: MAX_TRIES must be in 1..3");
    end

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic [PASS_W-1:0] shreg, shreg_nxt;
    logic [1:0]        fail_nxt;
    logic              sensor_nxt;

    logic              tmr_load;
    logic              tmr_dec;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;

    parking_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shreg_nxt = shreg;
        fail_nxt  = fail_cnt;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;

        case (state)
            S_IDLE: begin
                if (car_present) begin
                    state_nxt = S_COLLECT;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                end
            end

            S_COLLECT: begin
                if (!car_present) begin
                    state_nxt = S_IDLE;
                end else if (cancel) begin
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                end else if (key_valid) begin
                    shreg_nxt = {shreg[PASS_W-2:0], key_bit};
                    cnt_nxt   = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(PASS_W - 1)) begin
                        state_nxt = S_REQUEST;
                    end
                end
            end

            S_REQUEST: begin
                if (!car_present) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(RESP_TIMEOUT);
                end
            end

            S_WAIT: begin
                // A grant on the timer-zero cycle still wins over the timeout.
                if (!car_present) begin
                    state_nxt = S_IDLE;
                end else if (gate_ok) begin
                    state_nxt = S_GRANT;
                    fail_nxt  = 2'd0;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(GRANT_CYCLES - 1);
                end else if (tmr_zero) begin
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
`ifdef PARKING_LOCKOUT_EN
                    fail_nxt = fail_cnt + 2'd1;
                    if (fail_nxt == 2'(MAX_TRIES)) begin
                        state_nxt = S_LOCKOUT;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(LOCK_CYCLES - 1);
                    end else begin
                        state_nxt = S_COLLECT;
                    end
`else
                    if (fail_cnt != 2'd3) begin
                        fail_nxt = fail_cnt + 2'd1;
                    end
                    state_nxt = S_COLLECT;
`endif
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            S_GRANT: begin
                if (tmr_zero) begin
                    state_nxt = S_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

`ifdef PARKING_LOCKOUT_EN
            S_LOCKOUT: begin
                if (tmr_zero) begin
                    state_nxt = S_IDLE;
                    fail_nxt  = 2'd0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
`endif

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign sensor_nxt = (state_nxt == S_REQUEST) || (state_nxt == S_WAIT);

    // Outputs are registered from the next-state values so they line up with the state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            fail_cnt  <= 2'd0;
            sensor    <= 1'b0;
            pass      <= '0;
            entry_led <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            shreg     <= shreg_nxt;
            fail_cnt  <= fail_nxt;
            sensor    <= sensor_nxt;
            pass      <= sensor_nxt ? shreg_nxt : '0;
            entry_led <= (state_nxt == S_GRANT);
        end
    end

`ifdef PARKING_LOCKOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            lockout <= 1'b0;
        end else begin
            lockout <= (state_nxt == S_LOCKOUT);
        end
    end
`else
    assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_parking_keypad.sv
// Directed self-checking bench for parking_keypad with a registered gate model.
// Follows the PARKING_LOCKOUT_EN define to pick lockout or saturation expectations.
module tb_parking_keypad;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       car_present = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_bit = 1'b0;
    logic       cancel = 1'b0;
    logic       gate_man = 1'b0;
    logic       gate_auto = 1'b0;
    logic       grant_en = 1'b0;
    logic       gate_ok;
    logic       sensor;
    logic [3:0] pass;
    logic       entry_led;
    logic       lockout;
    logic [1:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    assign gate_ok = gate_man | gate_auto;

    always #5 clk = ~clk;

    // Gate controller model: registered grant when it sees the valid code requested.
    always @(posedge clk) gate_auto <= grant_en && sensor && (pass == 4'b1101);

    parking_keypad dut (
        .clk         (clk),
        .reset       (reset),
        .car_present (car_present),
        .key_valid   (key_valid),
        .key_bit     (key_bit),
        .cancel      (cancel),
        .gate_ok     (gate_ok),
        .sensor      (sensor),
        .pass        (pass),
        .entry_led   (entry_led),
        .lockout     (lockout),
        .fail_cnt    (fail_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        car_present = 1'b0;
        key_valid   = 1'b0;
        cancel      = 1'b0;
        gate_man    = 1'b0;
        grant_en    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic key(input logic b);
        key_valid = 1'b1;
        key_bit   = b;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter(input logic [3:0] code);
        for (int i = 3; i >= 0; i--) key(code[i]);
    endtask

    // Counts cycles with sensor high, starting from the current sample.
    task automatic sensor_run(output int n);
        n = 0;
        while (sensor && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int led_n;
        int lk;
        int sens_bad;

        // Reset state
        do_reset();
        check("rst_sensor", 32'(sensor), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_entry_led", 32'(entry_led), 0);
        check("rst_lockout", 32'(lockout), 0);
        check("rst_fail_cnt", 32'(fail_cnt), 0);

        // Correct code 1101 granted by the gate model
        car_present = 1'b1;
        grant_en    = 1'b1;
        tick();
        key(1'b1); key(1'b1); key(1'b0);
        check("ok_sensor_before_4th", 32'(sensor), 0);
        key(1'b1);
        check("ok_sensor_after_4th", 32'(sensor), 1);
        check("ok_pass", 32'(pass), 32'hD);
        led_n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (entry_led) led_n++;
        end
        check("ok_led_cycles", 32'(led_n), 8);
        check("ok_fail_cnt", 32'(fail_cnt), 0);
        check("ok_sensor_after", 32'(sensor), 0);
        grant_en = 1'b0;

        // Cancel together with key_valid discards the partial code
        do_reset();
        car_present = 1'b1;
        tick();
        key(1'b1); key(1'b1);
        cancel    = 1'b1;
        key_valid = 1'b1;
        key_bit   = 1'b1;
        tick();
        cancel    = 1'b0;
        key_valid = 1'b0;
        key(1'b1); key(1'b1); key(1'b0);
        check("cancel_no_early_req", 32'(sensor), 0);
        key(1'b1);
        check("cancel_sensor", 32'(sensor), 1);
        check("cancel_pass", 32'(pass), 32'hD);

        // Three failed attempts
        do_reset();
        car_present = 1'b1;
        tick();
        enter(4'b0110);
        check("fail1_pass", 32'(pass), 32'h6);
        sensor_run(n);
        check("fail1_sensor_len", 32'(n), 6);
        check("fail1_cnt", 32'(fail_cnt), 1);
        check("fail1_pass_idle", 32'(pass), 0);
        enter(4'b0110);
        sensor_run(n);
        check("fail2_cnt", 32'(fail_cnt), 2);
        enter(4'b0110);
        sensor_run(n);
        check("fail3_sensor_len", 32'(n), 6);
`ifdef PARKING_LOCKOUT_EN
        check("lock_asserted", 32'(lockout), 1);
        check("lock_fail_cnt", 32'(fail_cnt), 3);
        lk = 0;
        sens_bad = 0;
        while (lockout && lk < 40) begin
            key_valid = 1'b1;
            key_bit   = lk[0];
            cancel    = lk[1];
            tick();
            lk++;
            if (sensor || (pass != 4'b0000)) sens_bad++;
        end
        key_valid = 1'b0;
        cancel    = 1'b0;
        check("lock_cycles", 32'(lk), 16);
        check("lock_keys_ignored", 32'(sens_bad), 0);
        check("lock_exit_fail_cnt", 32'(fail_cnt), 0);
        tick();
        enter(4'b1001);
        check("lock_exit_new_pass", 32'(pass), 32'h9);
`else
        check("nolock_lockout", 32'(lockout), 0);
        check("nolock_fail_cnt", 32'(fail_cnt), 3);
        enter(4'b0110);
        check("nolock_retry_sensor", 32'(sensor), 1);
        sensor_run(n);
        check("nolock_saturate", 32'(fail_cnt), 3);
`endif

        // Car leaves during WAIT after one failure
        do_reset();
        car_present = 1'b1;
        tick();
        enter(4'b0110);
        sensor_run(n);
        enter(4'b0110);
        tick();
        check("drop_wait_sensor", 32'(sensor), 1);
        car_present = 1'b0;
        tick();
        check("drop_sensor", 32'(sensor), 0);
        check("drop_pass", 32'(pass), 0);
        check("drop_fail_cnt", 32'(fail_cnt), 1);

        // Reset in the second WAIT cycle
        do_reset();
        car_present = 1'b1;
        tick();
        enter(4'b0110);
        sensor_run(n);
        enter(4'b0110);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("midrst_sensor", 32'(sensor), 0);
        check("midrst_pass", 32'(pass), 0);
        check("midrst_fail_cnt", 32'(fail_cnt), 0);
        check("midrst_entry_led", 32'(entry_led), 0);
        check("midrst_lockout", 32'(lockout), 0);
        reset = 1'b1;

        // Grant arriving on the timer-zero cycle
        do_reset();
        car_present = 1'b1;
        tick();
        enter(4'b1101);
        for (int i = 0; i < 5; i++) tick();
        check("tz_still_waiting", 32'(sensor), 1);
        gate_man = 1'b1;
        tick();
        gate_man = 1'b0;
        check("tz_entry_led", 32'(entry_led), 1);
        check("tz_sensor", 32'(sensor), 0);
        check("tz_fail_cnt", 32'(fail_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
